nor_tree_pipe: RTL
==================

// Module: nor_tree_pipe
// PURPOSE
//  Parametrised, pipelined successor to the fixed 4-input NOR cell: reduces a WIDTH-bit vector
//  through a tree of 4-input OR groups, one register rank per tree level, with selectable
//  NOR/OR output. Valid/ready streaming interface; used as the wide zero-detect for datapaths.
// PARAMETERS
//  WIDTH   16  input vector width; legal 2..256
//  STAGES  derived = max(1, ceil(log4(WIDTH))); localparam, not overridable
// PORTS
//  ck         in   1      clock, rising edge
//  nrst       in   1      asynchronous reset, active low
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_data    in   WIDTH  vector to reduce
//  in_or      in   1      mode per beat: 0 = NOR (q=1 iff all zero), 1 = OR
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  q          out  1      reduction result
// BEHAVIOUR
//  - One clock ck; reset nrst is asynchronous, active low. On assertion, regardless of state:
//    all stage valids 0, all stage data 0, q=0, out_valid=0; in-flight beats are discarded.
//  - Stage k (1..STAGES) ORs groups of 4 bits of stage k-1 output; a partial last group is
//    padded with 0. Stage 1 input is in_data; stage STAGES produces one bit.
//  - in_or travels with its beat through every stage. Final register: q = in_or ? or : ~or.
//  - Global enable: en = !out_valid | out_ready. in_ready = en (combinational).
//    When en=1 every stage register (data, mode, valid) loads from the stage before;
//    stage 1 valid loads in_valid. When en=0 all stages hold.
//  - Accept = in_valid & in_ready; transfer out = out_valid & out_ready.
//  - Latency: beat accepted at edge t gives out_valid=1 after edge t+STAGES-1 with no stall.
//    Throughput 1 beat/cycle when out_ready held high.
//  - Bubbles propagate as valid=0; data in bubble stages is don't-care but must not reach q
//    while out_valid=0 (q holds last valid result).
//  - Stall: results never dropped or duplicated; q and out_valid stable while out_ready=0.
//  - out_ready may toggle with out_valid=0; no effect beyond en.
//  - in_data/in_or ignored when in_valid=0 or in_ready=0.
// CONFIGURATION
//  NOR_TREE_STICKY_EN defined: adds ports  clr in 1 (sync clear)  and  zero_seen out 1.
//    zero_seen sets at an output transfer whose reduced OR was 0 (all-zero input), either
//    mode; clr clears it; set and clr in same cycle -> set wins; reset value 0.
//  Not defined: ports clr/zero_seen absent; no sticky register; all else identical.
// STRUCTURE
//  Package nor_tree_pkg: function clog4(int) returning ceil(log4), STAGES helper,
//    function group_cnt(width,level) giving bit count after each level.
//  Sub-module nor_tree_stage #(IN_W): one tree level, combinational 4-way OR groups plus
//    en-gated data/mode/valid registers with async nrst; instantiated STAGES times in a generate.
//  Top holds enable logic, final mode inversion into q, and the optional sticky flag.
// TESTING
//  1 WIDTH=16: nrst low mid-stream with 2 beats in flight -> out_valid=0, q=0 at once; no
//    result emerges after release.
//  2 WIDTH=16, in_or=0, in_data=16'h0000 then 16'h0100, out_ready=1 -> q=1 then q=0,
//    out_valid rising 2 cycles after first accept, back-to-back.
//  3 WIDTH=16, in_or=1, in_data=16'h8000 -> q=1; in_data=16'h0000 -> q=0.
//  4 WIDTH=5, in_data=5'b10000 and 5'b00000, in_or=0 -> q=0 then 1 (padding, STAGES=2).
//  5 WIDTH=64, stream 8 beats, out_ready low for 4 cycles mid-stream -> in_ready=0 during
//    stall, all 8 results in order, none lost or repeated, latency 3.
//  6 NOR_TREE_STICKY_EN: all-zero beat transfers with clr=1 same cycle -> zero_seen=1;
//    next cycle clr=1 alone -> 0.

Source files
------------

// File: rtl/nor_tree_pkg.sv
// rtl/nor_tree_pkg.sv - sizing helpers for the pipelined 4-ary OR reduction tree
package nor_tree_pkg;

    function automatic int clog4(input int w);
        int r;
        int v;
        r = 0;
        v = 1;
        for (int i = 0; i < 8; i++) begin
            if (v < w) begin
                v = v * 4;
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic int stages_for(input int w);
        return (clog4(w) < 1) ? 1 : clog4(w);
    endfunction

    // Bits remaining after `level` tree levels (level 0 is the raw input).
    function automatic int group_cnt(input int width, input int level);
        int c;
        c = width;
        for (int i = 0; i < level; i++) c = (c + 3) / 4;
        return c;
    endfunction

    // Offset of each level's vector inside the flattened inter-stage bus.
    function automatic int bus_off(input int width, input int level);
        int o;
        o = 0;
        for (int i = 0; i < level; i++) o = o + group_cnt(width, i);
        return o;
    endfunction

endpackage

// File: rtl/nor_tree_stage.sv
// rtl/nor_tree_stage.sv - one tree level: 4-way OR groups plus enable-gated pipeline register
module nor_tree_stage
    import nor_tree_pkg::*;
#(
    parameter int   IN_W     = 4,
    parameter bit   MODE_RST = 1'b0,
    localparam int  OUT_W    = (IN_W + 3) / 4
) (
    input  logic             ck,
    input  logic             nrst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_mode
);

    logic [OUT_W*4-1:0] padded;
    logic [OUT_W-1:0]   grp;

    always_comb begin
        padded = '0;
        grp    = '0;
        padded[IN_W-1:0] = in_data;
        for (int g = 0; g < OUT_W; g++) grp[g] = |padded[4*g +: 4];
    end

    // Data and mode only load on a real beat, so bubbles never disturb the held result.
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= MODE_RST;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= grp;
                out_mode <= in_mode;
            end
        end
    end

endmodule

// File: rtl/nor_tree_pipe.sv
// rtl/nor_tree_pipe.sv - pipelined WIDTH-bit NOR/OR zero-detect; NOR_TREE_STICKY_EN adds clr/zero_seen
module nor_tree_pipe
    import nor_tree_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             ck,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_or,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             q
`ifdef NOR_TREE_STICKY_EN
    ,
    input  logic             clr,
    output logic             zero_seen
`endif
);

    localparam int STAGES   = stages_for(WIDTH);
    localparam int BUS_W    = bus_off(WIDTH, STAGES + 1);
    localparam int OFF_LAST = bus_off(WIDTH, STAGES);

    logic              en;
    logic [BUS_W-1:0]  bus;
    logic [STAGES:0]   v_s;
    logic [STAGES:0]   m_s;
    logic              last_or;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign bus[WIDTH-1:0] = in_data;
    assign v_s[0]         = in_valid;
    assign m_s[0]         = in_or;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam int IN_W    = group_cnt(WIDTH, k - 1);
        localparam int OUT_W   = group_cnt(WIDTH, k);
        localparam int OFF_IN  = bus_off(WIDTH, k - 1);
        localparam int OFF_OUT = bus_off(WIDTH, k);

        // Final rank resets its mode to OR so that q reads 0 straight out of reset.
        nor_tree_stage #(
            .IN_W     (IN_W),
            .MODE_RST (k == STAGES)
        ) u_stage (
            .ck        (ck),
            .nrst      (nrst),
            .en        (en),
            .in_valid  (v_s[k-1]),
            .in_data   (bus[OFF_IN +: IN_W]),
            .in_mode   (m_s[k-1]),
            .out_valid (v_s[k]),
            .out_data  (bus[OFF_OUT +: OUT_W]),
            .out_mode  (m_s[k])
        );
    end

    assign last_or   = bus[OFF_LAST];
    assign out_valid = v_s[STAGES];
    assign q         = m_s[STAGES] ? last_or : ~last_or;

`ifdef NOR_TREE_STICKY_EN
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            zero_seen <= 1'b0;
        end else if (out_valid && out_ready && !last_or) begin
            zero_seen <= 1'b1;
        end else if (clr) begin
            zero_seen <= 1'b0;
        end
    end
`endif

endmodule
